cv32e40p_obi_mem_arbiter: RTL
=============================

// Module: cv32e40p_obi_mem_arbiter
// PURPOSE
//  Sits directly downstream of the core wrapper's data and shadow-store OBI master ports.
//  Merges the two ports onto a single OBI memory port.
//  Arbitration is round-robin with lock. A FIFO of source tags tracks outstanding
//  transactions and routes each in-order rvalid/rdata back to the port that issued it.
// PARAMETERS
//  MAX_OUTSTANDING  2   max accepted-but-unanswered transactions on mem port (>=1, power of 2)
//  ADDR_WIDTH       32  address width
//  DATA_WIDTH       32  data width; byte-enable width is DATA_WIDTH/8
// PORTS
//  clk_i            in   1        clock
//  rst_i            in   1        asynchronous active-high reset
//  data_req_i       in   1        core data port request
//  data_gnt_o       out  1        grant to core data port
//  data_rvalid_o    out  1        response valid to core data port
//  data_we_i        in   1        write enable
//  data_be_i        in   BE       byte enables
//  data_addr_i      in   AW       address
//  data_wdata_i     in   DW       write data
//  data_rdata_o     out  DW       read data
//  shadow_*         -    -        same set as data_* (req_i, gnt_o, rvalid_o, we_i, be_i, addr_i, wdata_i, rdata_o)
//  mem_req_o        out  1        merged request
//  mem_gnt_i        in   1        memory grant
//  mem_rvalid_i     in   1        memory response valid; responses return in order
//  mem_we_o         out  1        write enable
//  mem_be_o         out  BE       byte enables
//  mem_addr_o       out  AW       address
//  mem_wdata_o      out  DW       write data
//  mem_rdata_i      in   DW       read data
// BEHAVIOUR
//  Reset:
//   - mem_req_o, both gnt_o, both rvalid_o = 0; mem_* address-phase outputs = 0.
//   - Tag FIFO empty; RR pointer = DATA; lock cleared.
//  Arbitration:
//   - States IDLE/LOCKED.
//   - IDLE: if FIFO not full and any req, pick a source. Both requesting -> the one the
//     RR pointer selects; otherwise the sole requester. Drive mem_req_o=1 and mux its
//     address phase the same cycle (zero added latency). If mem_gnt_i=0, go LOCKED.
//   - LOCKED: keep the same source on mem_* until mem_gnt_i=1, regardless of the other
//     requester (OBI address-phase stability). Then go IDLE.
//  Grant and accept:
//   - gnt_o of the selected source = mem_gnt_i & mem_req_o; the other gnt_o = 0.
//   - On accept (mem_req_o & mem_gnt_i):
//     - push source tag.
//     - RR pointer moves to the other source.
//  Full:
//   - FIFO holds MAX_OUTSTANDING tags -> mem_req_o=0 in IDLE; no new accept.
//   - A pop in the same cycle does NOT unblock; there is no comb path rvalid->req.
//   - LOCKED is never entered while full, because an accept only occurs when not full.
//  Response:
//   - mem_rvalid_i pops the head tag. The tagged port's rvalid_o = 1 and its
//     rdata_o = mem_rdata_i, combinationally, with zero latency.
//   - rdata_o of both ports is always mem_rdata_i (unmuxed); only rvalid_o is steered.
//  Simultaneous events:
//   - Push and pop in the same cycle: occupancy unchanged; the pop reads the old head.
//   - Empty FIFO plus push and pop in the same cycle is illegal (OBI: rvalid follows
//     gnt by at least 1 cycle).
//  Error:
//   - mem_rvalid_i with an empty FIFO: no rvalid_o is driven.
//   - Assertion cv32e40p_obi_mem_arbiter_sva flags it.
//  Reset mid-operation: outstanding tags are discarded. The memory side is reset in the
//   same domain, so no stale rvalid is expected.
//  Occupancy:
//   - Counter width $clog2(MAX_OUTSTANDING)+1.
//   - Read/write pointers wrap modulo MAX_OUTSTANDING.
// STRUCTURE
//  - cv32e40p_pkg: typedef enum logic {OBI_SRC_DATA, OBI_SRC_SHADOW} obi_src_e.
//  - Sub-module cv32e40p_obi_tag_fifo: DEPTH, element obi_src_e, push/pop/full/empty/head.
//  - Top: arbitration FSM, RR pointer, muxes.
// TESTING
//  1. Data-only read: data req, addr=0x100, mem_gnt same cycle -> mem_addr_o=0x100;
//     rvalid 2 cycles later -> data_rvalid_o=1 with rdata, shadow_rvalid_o=0.
//  2. Both req every cycle, gnt always 1 -> grants alternate DATA, SHADOW, DATA...;
//     rvalids are routed in the same order.
//  3. Data req, mem_gnt held 0 for 3 cycles while shadow asserts req -> mem_addr_o stays
//     at the data address until gnt; shadow is granted next.
//  4. MAX_OUTSTANDING=2: two accepts, no rvalid -> mem_req_o=0. An rvalid in cycle N
//     -> mem_req_o=1 at N+1, not at N.
//  5. Push and pop in the same cycle at occupancy 1 -> occupancy stays 1; the pop routes
//     to the older tag.
//  6. rst_i asserted with 2 outstanding -> all outputs 0 and FIFO empty; after release
//     the first grant goes to DATA.

Source files
------------

// File: rtl/cv32e40p_pkg.sv
// Shared types for the OBI data/shadow-store memory arbiter.
package cv32e40p_pkg;

  typedef enum logic {
    OBI_SRC_DATA   = 1'b0,
    OBI_SRC_SHADOW = 1'b1
  } obi_src_e;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } obi_arb_state_e;

  function automatic obi_src_e obi_other_src(input obi_src_e src);
    return (src == OBI_SRC_DATA) ? OBI_SRC_SHADOW : OBI_SRC_DATA;
  endfunction

endpackage

// File: rtl/cv32e40p_obi_tag_fifo.sv
// In-order FIFO of source tags for accepted-but-unanswered OBI transactions.
module cv32e40p_obi_tag_fifo
  import cv32e40p_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     push_i,
  input  obi_src_e data_i,
  input  logic     pop_i,
  output logic     full_o,
  output logic     empty_o,
  output obi_src_e head_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  obi_src_e         mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q;
  logic [PTR_W-1:0] rd_q;
  logic [CNT_W-1:0] cnt_q;
  logic             push_ok;
  logic             pop_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_q];
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= OBI_SRC_DATA;
    end else begin
      if (push_ok) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= ptr_inc(wr_q);
      end
      if (pop_ok) rd_q <= ptr_inc(rd_q);
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/cv32e40p_obi_mem_arbiter.sv
// Merges the core data and shadow-store OBI ports onto one memory port with
// round-robin arbitration, address-phase locking and in-order response routing.
module cv32e40p_obi_mem_arbiter
  import cv32e40p_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,

  input  logic                    data_req_i,
  output logic                    data_gnt_o,
  output logic                    data_rvalid_o,
  input  logic                    data_we_i,
  input  logic [DATA_WIDTH/8-1:0] data_be_i,
  input  logic [ADDR_WIDTH-1:0]   data_addr_i,
  input  logic [DATA_WIDTH-1:0]   data_wdata_i,
  output logic [DATA_WIDTH-1:0]   data_rdata_o,

  input  logic                    shadow_req_i,
  output logic                    shadow_gnt_o,
  output logic                    shadow_rvalid_o,
  input  logic                    shadow_we_i,
  input  logic [DATA_WIDTH/8-1:0] shadow_be_i,
  input  logic [ADDR_WIDTH-1:0]   shadow_addr_i,
  input  logic [DATA_WIDTH-1:0]   shadow_wdata_i,
  output logic [DATA_WIDTH-1:0]   shadow_rdata_o,

  output logic                    mem_req_o,
  input  logic                    mem_gnt_i,
  input  logic                    mem_rvalid_i,
  output logic                    mem_we_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

  obi_arb_state_e state_q;
  obi_src_e       lock_src_q;
  obi_src_e       rr_q;
  obi_src_e       sel_src;
  obi_src_e       head_src;
  logic           sel_valid;
  logic           accept;
  logic           pop;
  logic           fifo_full;
  logic           fifo_empty;

  // Reset gates the request so every output reads zero while rst_i is high.
  always_comb begin
    sel_src   = rr_q;
    sel_valid = 1'b0;
    if (state_q == ARB_LOCKED) begin
      sel_src   = lock_src_q;
      sel_valid = 1'b1;
    end else begin
      sel_valid = !fifo_full && (data_req_i || shadow_req_i);
      if (data_req_i && shadow_req_i) sel_src = rr_q;
      else if (data_req_i)            sel_src = OBI_SRC_DATA;
      else                            sel_src = OBI_SRC_SHADOW;
    end
    if (rst_i) sel_valid = 1'b0;
  end

  assign mem_req_o    = sel_valid;
  assign accept       = sel_valid && mem_gnt_i;
  assign data_gnt_o   = accept && (sel_src == OBI_SRC_DATA);
  assign shadow_gnt_o = accept && (sel_src == OBI_SRC_SHADOW);

  always_comb begin
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (sel_valid) begin
      if (sel_src == OBI_SRC_DATA) begin
        mem_we_o    = data_we_i;
        mem_be_o    = data_be_i;
        mem_addr_o  = data_addr_i;
        mem_wdata_o = data_wdata_i;
      end else begin
        mem_we_o    = shadow_we_i;
        mem_be_o    = shadow_be_i;
        mem_addr_o  = shadow_addr_i;
        mem_wdata_o = shadow_wdata_i;
      end
    end
  end

  assign pop             = mem_rvalid_i && !fifo_empty && !rst_i;
  assign data_rvalid_o   = pop && (head_src == OBI_SRC_DATA);
  assign shadow_rvalid_o = pop && (head_src == OBI_SRC_SHADOW);
  assign data_rdata_o    = mem_rdata_i;
  assign shadow_rdata_o  = mem_rdata_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ARB_IDLE;
      lock_src_q <= OBI_SRC_DATA;
      rr_q       <= OBI_SRC_DATA;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (sel_valid && !mem_gnt_i) begin
            state_q    <= ARB_LOCKED;
            lock_src_q <= sel_src;
          end
        end
        ARB_LOCKED: begin
          if (mem_gnt_i) state_q <= ARB_IDLE;
        end
        default: state_q <= ARB_IDLE;
      endcase
      if (accept) rr_q <= obi_other_src(sel_src);
    end
  end

  cv32e40p_obi_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (accept),
    .data_i  (sel_src),
    .pop_i   (pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (head_src)
  );

  cv32e40p_obi_mem_arbiter_sva: assert property (
    @(posedge clk_i) disable iff (rst_i) !(mem_rvalid_i && fifo_empty)
  );

endmodule
